// File: rtl/matvec_pkg.sv
// Shared types and width helpers for the matrix-vector sequencer.
package matvec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } mv_state_e;

    // Exact width of a sum of n products of two dw-bit unsigned values.
    function automatic int unsigned calc_ow(input int unsigned n, input int unsigned dw);
        return 2 * dw + $clog2(n);
    endfunction

    // Row index width, never below one bit.
    function automatic int unsigned calc_iw(input int unsigned m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/inner_product.sv
// Combinational unsigned dot product of two packed N-element vectors.
module inner_product
    import matvec_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned DW = 8,
    localparam int unsigned PW = calc_ow(N, DW)
) (
    input  logic [N*DW-1:0] a,
    input  logic [N*DW-1:0] b,
    output logic [PW-1:0]   sum
);

    // Accumulate element-wise products; PW is wide enough that nothing overflows.
    always_comb begin
        sum = '0;
        for (int k = 0; k < int'(N); k++) begin
            sum = sum + PW'(a[k*DW +: DW]) * PW'(b[k*DW +: DW]);
        end
    end

endmodule

// File: rtl/matvec_sequencer.sv
// Latches an operand vector and streams M rows through one inner_product unit.
module matvec_sequencer
    import matvec_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned DW = 8,
    parameter  int unsigned M  = 4,
    localparam int unsigned OW = calc_ow(N, DW),
    localparam int unsigned IW = calc_iw(M)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            vec_valid,
    output logic            vec_ready,
    input  logic [N*DW-1:0] vec_data,
    input  logic            row_valid,
    output logic            row_ready,
    input  logic [N*DW-1:0] row_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [OW-1:0]   res_data,
    output logic [IW-1:0]   res_idx,
    output logic            res_last,
    output logic            busy,
    output logic            done
);

    localparam int unsigned PW = calc_ow(N, DW);

    mv_state_e         state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic [N*DW-1:0]   vec_q, vec_d;
    logic              res_valid_q, res_valid_d;
    logic [OW-1:0]     res_data_q, res_data_d;
    logic [IW-1:0]     res_idx_q, res_idx_d;
    logic              res_last_q, res_last_d;
    logic              done_q, done_d;
    logic [PW-1:0]     ip_sum;
    logic              row_hs;
    logic              res_hs;
    logic              cnt_last;

    inner_product #(.N(N), .DW(DW)) u_inner_product (
        .a   (row_data),
        .b   (vec_q),
        .sum (ip_sum)
    );

    // Handshake ports: a new row may enter whenever the result slot is free or being emptied.
    always_comb begin
        vec_ready = (state_q == ST_IDLE);
        row_ready = (state_q == ST_RUN) && (!res_valid_q || res_ready);
        busy      = (state_q != ST_IDLE);
        row_hs    = row_ready && row_valid;
        res_hs    = res_valid_q && res_ready;
        cnt_last  = (cnt_q == IW'(M - 1));
    end

    // Next-state, counter, vector and result register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_last_d  = res_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (vec_valid) begin
                    vec_d   = vec_data;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (row_hs) begin
                    cnt_d = cnt_q + IW'(1);
                    if (cnt_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (res_hs && res_last_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A take with a simultaneous new row overwrites in place, keeping valid high.
        if (row_hs) begin
            res_valid_d = 1'b1;
            res_data_d  = OW'(ip_sum);
            res_idx_d   = cnt_q;
            res_last_d  = cnt_last;
        end else if (res_hs) begin
            res_valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            vec_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_last_q  <= res_last_d;
            done_q      <= done_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign res_last  = res_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer: M=3 main instance plus an M=1 instance.
module tb_matvec_sequencer;

    logic        clk;
    logic        rst_n;
    logic        vec_valid, vec_ready, row_valid, row_ready;
    logic [31:0] vec_data, row_data;
    logic        res_valid, res_ready, res_last, busy, done;
    logic [17:0] res_data;
    logic [1:0]  res_idx;

    logic        u1_vec_valid, u1_vec_ready, u1_row_valid, u1_row_ready;
    logic [31:0] u1_vec_data, u1_row_data;
    logic        u1_res_valid, u1_res_ready, u1_res_last, u1_busy, u1_done;
    logic [17:0] u1_res_data;
    logic [0:0]  u1_res_idx;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] vec;
        logic [31:0] row;
        logic [17:0] data;
        logic [1:0]  idx;
        logic        last;
    } vec_t;

    vec_t tbl[6];

    matvec_sequencer #(.N(4), .DW(8), .M(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .res_last(res_last), .busy(busy), .done(done)
    );

    matvec_sequencer #(.N(4), .DW(8), .M(1)) dut_m1 (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(u1_vec_valid), .vec_ready(u1_vec_ready), .vec_data(u1_vec_data),
        .row_valid(u1_row_valid), .row_ready(u1_row_ready), .row_data(u1_row_data),
        .res_valid(u1_res_valid), .res_ready(u1_res_ready), .res_data(u1_res_data),
        .res_idx(u1_res_idx), .res_last(u1_res_last), .busy(u1_busy), .done(u1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int e);
        chk({tag, " res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, " res_data"},  32'(res_data),  32'(tbl[e].data));
        chk({tag, " res_idx"},   32'(res_idx),   32'(tbl[e].idx));
        chk({tag, " res_last"},  32'(res_last),  32'(tbl[e].last));
    endtask

    // Full matrix with res_ready high; optionally offer a junk vector during RUN.
    task automatic run_matrix(input int g, input bit poke);
        res_ready = 1'b1;
        @(negedge clk);
        vec_valid = 1'b1;
        vec_data  = tbl[g*3].vec;
        #1 chk("idle vec_ready", 32'(vec_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_valid = poke;
            vec_data  = poke ? 32'hFFFF_FFFF : 32'h0;
            row_valid = 1'b1;
            row_data  = tbl[g*3+i].row;
            #1;
            chk("run row_ready", 32'(row_ready), 32'd1);
            chk("run busy", 32'(busy), 32'd1);
            if (poke) chk("run vec_ready", 32'(vec_ready), 32'd0);
            if (i == 0) chk("first res_valid", 32'(res_valid), 32'd0);
            else chk_res("row", g*3+i-1);
        end
        @(negedge clk);
        row_valid = 1'b0;
        vec_valid = 1'b0;
        #1;
        chk_res("last", g*3+2);
        chk("drain row_ready", 32'(row_ready), 32'd0);
        chk("drain done", 32'(done), 32'd0);
        @(negedge clk);
        chk("done pulse", 32'(done), 32'd1);
        chk("done vec_ready", 32'(vec_ready), 32'd1);
        chk("done busy", 32'(busy), 32'd0);
        chk("done res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("done cleared", 32'(done), 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'h04030201, 32'h01010101, 18'd10,     2'd0, 1'b0};
        tbl[1] = '{32'h04030201, 32'h01000000, 18'd4,      2'd1, 1'b0};
        tbl[2] = '{32'h04030201, 32'h00000002, 18'd2,      2'd2, 1'b1};
        tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 18'h3F804,  2'd0, 1'b0};
        tbl[4] = '{32'hFFFFFFFF, 32'h000000FF, 18'd65025,  2'd1, 1'b0};
        tbl[5] = '{32'hFFFFFFFF, 32'h01010101, 18'd1020,   2'd2, 1'b1};

        rst_n = 1'b0;
        vec_valid = 1'b0; vec_data = '0; row_valid = 1'b0; row_data = '0; res_ready = 1'b1;
        u1_vec_valid = 1'b0; u1_vec_data = '0; u1_row_valid = 1'b0; u1_row_data = '0;
        u1_res_ready = 1'b1;
        #12;
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst res_data", 32'(res_data), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst vec_ready", 32'(vec_ready), 32'd1);
        chk("rst done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main function and max-value matrices.
        run_matrix(0, 1'b0);
        run_matrix(1, 1'b0);

        // Rows offered in IDLE are ignored.
        row_valid = 1'b1;
        row_data  = 32'h01010101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle row_ready", 32'(row_ready), 32'd0);
            chk("idle res_valid", 32'(res_valid), 32'd0);
        end
        row_valid = 1'b0;

        // Vector offered during RUN must not disturb the held vector.
        run_matrix(0, 1'b1);

        // Backpressure: stall five cycles after the first result.
        @(negedge clk);
        vec_valid = 1'b1; vec_data = tbl[0].vec;
        @(negedge clk);
        vec_valid = 1'b0;
        row_valid = 1'b1; row_data = tbl[0].row;
        @(negedge clk);
        res_ready = 1'b0;
        row_data  = tbl[1].row;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp row_ready", 32'(row_ready), 32'd0);
            chk_res("bp hold", 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1 chk("bp release row_ready", 32'(row_ready), 32'd1);
        @(negedge clk);
        row_data = tbl[2].row;
        #1 chk_res("bp row1", 1);
        @(negedge clk);
        row_valid = 1'b0;
        #1 chk_res("bp row2", 2);
        @(negedge clk);
        chk("bp done", 32'(done), 32'd1);
        chk("bp res_valid", 32'(res_valid), 32'd0);

        // Asynchronous reset with a pending result.
        @(negedge clk);
        vec_valid = 1'b1; vec_data = tbl[0].vec;
        @(negedge clk);
        vec_valid = 1'b0;
        row_valid = 1'b1; row_data = tbl[0].row;
        @(negedge clk);
        row_data = tbl[1].row;
        @(negedge clk);
        row_valid = 1'b0;
        #1 chk_res("pre-rst", 1);
        rst_n = 1'b0;
        #1;
        chk("arst res_valid", 32'(res_valid), 32'd0);
        chk("arst res_data", 32'(res_data), 32'd0);
        chk("arst res_idx", 32'(res_idx), 32'd0);
        chk("arst res_last", 32'(res_last), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst vec_ready", 32'(vec_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post-rst done", 32'(done), 32'd0);
        end
        run_matrix(0, 1'b0);

        // Single-row matrix.
        @(negedge clk);
        u1_vec_valid = 1'b1; u1_vec_data = 32'h00000003;
        @(negedge clk);
        u1_vec_valid = 1'b0;
        u1_row_valid = 1'b1; u1_row_data = 32'h00000005;
        #1 chk("m1 row_ready", 32'(u1_row_ready), 32'd1);
        @(negedge clk);
        u1_row_valid = 1'b0;
        #1;
        chk("m1 res_valid", 32'(u1_res_valid), 32'd1);
        chk("m1 res_data", 32'(u1_res_data), 32'd15);
        chk("m1 res_idx", 32'(u1_res_idx), 32'd0);
        chk("m1 res_last", 32'(u1_res_last), 32'd1);
        chk("m1 drain row_ready", 32'(u1_row_ready), 32'd0);
        @(negedge clk);
        chk("m1 done", 32'(u1_done), 32'd1);
        chk("m1 busy", 32'(u1_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
